// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter : round-robin write arbiter with credit-tracked FIFO occupancy
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int BITS  = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BITS-1:0]      din,
  output logic [N_REQ-1:0]           ack,
  output logic [BITS-1:0]            fifo_Din,
  output logic                       fifo_push,
  input  logic                       fifo_pop,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [CW-1:0]              count
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] ack_q,   ack_d;
  logic             push_q,  push_d;
  logic [BITS-1:0]  din_q,   din_d;
  logic [IW-1:0]    gid_q,   gid_d;
  logic [IW-1:0]    last_q,  last_d;
  logic [CW-1:0]    count_q, count_d;

  logic [N_REQ-1:0] eligible;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic             grant;
  logic             pop_eff;

  always_comb begin
    // A producer acked this cycle sits out one round.
    eligible  = req & ~ack_q;
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!win_found && eligible[(int'(last_q) + off) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last_q) + off) % N_REQ);
      end
    end

    // Credits are checked against the registered count only: no pop bypass.
    grant   = win_found && (count_q < CW'(DEPTH));
    pop_eff = fifo_pop && (count_q != '0);

    ack_d   = '0;
    push_d  = grant;
    din_d   = din_q;
    gid_d   = gid_q;
    last_d  = last_q;
    if (grant) begin
      ack_d  = N_REQ'(1) << win_idx;
      din_d  = din[int'(win_idx)*BITS +: BITS];
      gid_d  = win_idx;
      last_d = win_idx;
    end
    count_d = count_q + CW'(grant) - CW'(pop_eff);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q   <= '0;
      push_q  <= 1'b0;
      din_q   <= '0;
      gid_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      count_q <= '0;
    end else begin
      ack_q   <= ack_d;
      push_q  <= push_d;
      din_q   <= din_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign ack       = ack_q;
  assign fifo_push = push_q;
  assign fifo_Din  = din_q;
  assign grant_id  = gid_q;
  assign count     = count_q;

endmodule

`default_nettype wire
